ysyx_23060020_seq_ctrl: RTL
===========================

// Module: ysyx_23060020_seq_ctrl
// PURPOSE
//   Multi-cycle sequencer for the core datapath. Steps one instruction at a time through
//   fetch, decode, execute, memory and writeback, with req/response handshakes to instruction
//   and data memory. Sits between the instruction decoder (class flags) and the PC, IR,
//   register-file and LSU enables; it replaces the fixed single-cycle PC/RF enables.
//   Halts on ebreak. Traps on an illegal instruction or a bus timeout.
// PARAMETERS
//   TMO_CYCLES  255  max wait cycles for a memory response before trap (1..2^16-1)
//   CNT_W       64   width of the retired-instruction counter
// PORTS
//   clk          input   1      clock; all state updates on rising edge
//   rst_n        input   1      synchronous reset, active low
//   imem_req     output  1      fetch request; held high in FETCH until imem_rvalid
//   imem_rvalid  input   1      instruction word valid this cycle
//   ir_we        output  1      latch instruction into IR (= FETCH & imem_rvalid)
//   dec_load     input   1      decoder class flag: load
//   dec_store    input   1      decoder class flag: store
//   dec_ebreak   input   1      decoder class flag: ebreak (0x00100073)
//   dec_illegal  input   1      decoder class flag: no legal decode
//   rf_wen_in    input   1      decoder register-file write enable
//   rf_wen       output  1      gated RF write strobe
//   pc_we        output  1      PC update strobe
//   dmem_req     output  1      data access request; held high in MEM until dmem_done
//   dmem_wen     output  1      data access is a write (= MEM & dec_store)
//   dmem_done    input   1      data access complete this cycle
//   halt         output  1      sticky: ebreak retired
//   trap         output  1      sticky: trap taken
//   trap_cause   output  2      00 none, 01 illegal, 10 imem timeout, 11 dmem timeout
//   instret      output  CNT_W  retired-instruction count
// BEHAVIOUR
//   - Reset (rst_n=0 at edge): state=FETCH, wcnt=0, instret=0, halt=trap=0, trap_cause=00.
//     Every strobe is combinational from state and is therefore 0 outside its state.
//   - FETCH: imem_req=1. imem_rvalid -> DECODE. Otherwise wcnt++; when wcnt reaches
//     TMO_CYCLES -> TRAP, cause 10.
//   - DECODE: one cycle; flags are taken from the latched IR. Priority: dec_illegal -> TRAP
//     cause 01; dec_ebreak -> HALT with instret+1; otherwise -> EXEC.
//   - EXEC: one cycle. dec_load|dec_store -> MEM; otherwise -> WB.
//   - MEM: dmem_req=1. dmem_done -> WB. Otherwise wcnt++; timeout -> TRAP, cause 11.
//   - WB: one cycle. rf_wen = rf_wen_in & ~dec_store; pc_we=1; instret+1; -> FETCH.
//   - HALT / TRAP: terminal until reset. All strobes 0; halt/trap held at 1.
//   - Latency with zero-wait memory: ALU/auipc 4 cycles (F,D,E,W); load/store 5 cycles.
//   - wcnt is cleared on every state entry.
//   - If a response arrives in the same cycle that wcnt reaches TMO_CYCLES, the response wins.
//   - imem_rvalid outside FETCH and dmem_done outside MEM are ignored.
//   - instret wraps modulo 2^CNT_W.
//   - Reset asserted mid-MEM: dmem_req drops the next cycle; no writeback and no instret update.
//   - Decoder flags must stay stable from DECODE through WB; IR is written only by ir_we.
// STRUCTURE
//   - Package ysyx_23060020_pkg: state encoding constants (3-bit: FETCH, DECODE, EXEC, MEM,
//     WB, HALT, TRAP) and trap-cause constants.
//   - Sub-module ysyx_23060020_tmo_cnt: wait counter with clear, enable and an expire output
//     at TMO_CYCLES. Instantiated once and shared by FETCH and MEM.
//   - The FSM next-state and output logic stays in this module.
// TESTING
//   1. Reset release, addi with zero-wait imem -> imem_req@c0, ir_we@c0, pc_we+rf_wen@c3,
//      instret=1, imem_req again@c4.
//   2. Load with dmem_done 3 cycles late -> dmem_req high 4 cycles, rf_wen=1 once,
//      instret+1, dmem_wen=0.
//   3. Store -> dmem_wen=1 throughout MEM, rf_wen=0 in WB even with rf_wen_in=1, pc_we=1.
//   4. imem_rvalid never asserted, TMO_CYCLES=4 -> trap=1, cause=10 after 5 FETCH cycles;
//      all strobes 0 afterwards.
//   5. dec_illegal=1 and dec_ebreak=1 together -> TRAP, cause 01, halt=0, instret unchanged.
//      ebreak alone -> halt=1, instret+1.
//   6. rst_n low during MEM, then released -> state FETCH, instret=0, dmem_req=0 the
//      cycle after reset.

Source files
------------

// File: rtl/ysyx_23060020_pkg.sv
// rtl/ysyx_23060020_pkg.sv - state and trap-cause constants for the multi-cycle sequencer
package ysyx_23060020_pkg;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;
    localparam logic [2:0] ST_TRAP   = 3'd6;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b01;
    localparam logic [1:0] CAUSE_IMEM_TMO = 2'b10;
    localparam logic [1:0] CAUSE_DMEM_TMO = 2'b11;

    // Terminal states are left only through reset.
    function automatic logic is_terminal(input logic [2:0] st);
        return (st == ST_HALT) || (st == ST_TRAP);
    endfunction

endpackage

// File: rtl/ysyx_23060020_tmo_cnt.sv
// rtl/ysyx_23060020_tmo_cnt.sv - shared memory-response wait counter with expiry flag
module ysyx_23060020_tmo_cnt #(
    parameter int TMO_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [15:0] wcnt;

    assign expire = (wcnt == 16'(TMO_CYCLES));

    // Saturate at the limit so a stalled enable never wraps back below it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wcnt <= '0;
        end else if (clr) begin
            wcnt <= '0;
        end else if (en && !expire) begin
            wcnt <= wcnt + 16'd1;
        end
    end

endmodule

// File: rtl/ysyx_23060020_seq_ctrl.sv
// rtl/ysyx_23060020_seq_ctrl.sv - multi-cycle fetch/decode/exec/mem/wb sequencer
module ysyx_23060020_seq_ctrl
    import ysyx_23060020_pkg::*;
#(
    parameter int TMO_CYCLES = 255,
    parameter int CNT_W      = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    input  logic             imem_rvalid,
    output logic             ir_we,
    input  logic             dec_load,
    input  logic             dec_store,
    input  logic             dec_ebreak,
    input  logic             dec_illegal,
    input  logic             rf_wen_in,
    output logic             rf_wen,
    output logic             pc_we,
    output logic             dmem_req,
    output logic             dmem_wen,
    input  logic             dmem_done,
    output logic             halt,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [1:0] cause_nxt;
    logic       retire;
    logic       cnt_clr;
    logic       cnt_en;
    logic       expire;

    always_comb begin
        state_nxt = state;
        cause_nxt = trap_cause;
        retire    = 1'b0;
        case (state)
            ST_FETCH: begin
                if (imem_rvalid) begin
                    state_nxt = ST_DECODE;
                end else if (expire) begin
                    state_nxt = ST_TRAP;
                    cause_nxt = CAUSE_IMEM_TMO;
                end
            end
            ST_DECODE: begin
                if (dec_illegal) begin
                    state_nxt = ST_TRAP;
                    cause_nxt = CAUSE_ILLEGAL;
                end else if (dec_ebreak) begin
                    state_nxt = ST_HALT;
                    retire    = 1'b1;
                end else begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_nxt = (dec_load || dec_store) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                // A response in the expiry cycle still completes the access.
                if (dmem_done) begin
                    state_nxt = ST_WB;
                end else if (expire) begin
                    state_nxt = ST_TRAP;
                    cause_nxt = CAUSE_DMEM_TMO;
                end
            end
            ST_WB: begin
                state_nxt = ST_FETCH;
                retire    = 1'b1;
            end
            ST_HALT, ST_TRAP: begin
                state_nxt = state;
            end
            default: begin
                state_nxt = ST_TRAP;
            end
        endcase
    end

    // The wait count restarts whenever the FSM moves to a new state.
    assign cnt_clr = (state_nxt != state);
    assign cnt_en  = (state == ST_FETCH) || (state == ST_MEM);

    ysyx_23060020_tmo_cnt #(
        .TMO_CYCLES (TMO_CYCLES)
    ) u_tmo_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_FETCH;
            trap_cause <= CAUSE_NONE;
            instret    <= '0;
        end else begin
            state      <= state_nxt;
            trap_cause <= cause_nxt;
            if (retire) begin
                instret <= instret + CNT_W'(1);
            end
        end
    end

    assign imem_req = (state == ST_FETCH);
    assign ir_we    = (state == ST_FETCH) && imem_rvalid;
    assign pc_we    = (state == ST_WB);
    assign rf_wen   = (state == ST_WB) && rf_wen_in && !dec_store;
    assign dmem_req = (state == ST_MEM);
    assign dmem_wen = (state == ST_MEM) && dec_store;
    assign halt     = is_terminal(state) && (state == ST_HALT);
    assign trap     = is_terminal(state) && (state == ST_TRAP);

endmodule
